// File: rtl/adf4158_pkg.sv
// Shared constants, default register image and FSM state encoding for the
// ADF4158 power-up configuration sequencer.
package adf4158_pkg;

  localparam int unsigned NUM_WORDS  = 10;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned IDX_W      = 4;

  localparam logic [WORD_WIDTH-1:0] R7_DEFAULT  = 32'h0000_0007;
  localparam logic [WORD_WIDTH-1:0] R6A_DEFAULT = 32'h0000_0006;
  localparam logic [WORD_WIDTH-1:0] R6B_DEFAULT = 32'h0080_0006;
  localparam logic [WORD_WIDTH-1:0] R5A_DEFAULT = 32'h0000_0005;
  localparam logic [WORD_WIDTH-1:0] R5B_DEFAULT = 32'h0080_0005;
  localparam logic [WORD_WIDTH-1:0] R4_DEFAULT  = 32'h0018_0104;
  localparam logic [WORD_WIDTH-1:0] R3_DEFAULT  = 32'h0000_0043;
  localparam logic [WORD_WIDTH-1:0] R2_DEFAULT  = 32'h0040_800A;
  localparam logic [WORD_WIDTH-1:0] R1_DEFAULT  = 32'h0000_0001;
  localparam logic [WORD_WIDTH-1:0] R0_DEFAULT  = 32'h803C_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CE_WAIT,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adf4158_spi_word.sv
// Serialises one 32-bit word MSB first on sclk/data, then pulses le and a gap.
// done_c_o marks the last gap cycle so the next word can start back-to-back.
module adf4158_spi_word
  import adf4158_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  output logic                  sclk_o,
  output logic                  data_o,
  output logic                  le_o,
  output logic                  done_c_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  phase_q, phase_d;   // 0: sclk low half, 1: sclk high half
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;   // bits still to send, next one in MSB
  logic                  sclk_q, sclk_d;
  logic                  data_q, data_d;
  logic                  le_q, le_d;
  logic                  div_end;
  logic                  load;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    data_d   = data_q;
    le_d     = le_q;
    done_c_o = 1'b0;
    load     = 1'b0;
    div_end  = (div_q == DIV_LAST);

    case (state_q)
      ST_IDLE: load = start_i;
      ST_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (div_end) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
            sclk_d  = 1'b0;
            data_d  = 1'b0;
            le_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            data_d  = shreg_q[WORD_WIDTH-1];
            shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_LATCH: begin
        div_d = div_q + DIV_W'(1);
        if (div_end) begin
          div_d   = '0;
          le_d    = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        div_d = div_q + DIV_W'(1);
        if (div_end) begin
          div_d    = '0;
          done_c_o = 1'b1;
          state_d  = ST_IDLE;
          load     = start_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_SHIFT;
      div_d   = '0;
      bit_d   = '0;
      phase_d = 1'b0;
      sclk_d  = 1'b0;
      le_d    = 1'b0;
      data_d  = word_i[WORD_WIDTH-1];
      shreg_d = {word_i[WORD_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      le_q    <= le_d;
    end
  end

  assign sclk_o = sclk_q;
  assign data_o = data_q;
  assign le_o   = le_q;

endmodule

// File: rtl/adf4158_config.sv
// ADF4158 power-up sequencer: raise ce, wait CE_DELAY, write ten register words
// over the 3-wire bus, then hold config_done until reset.
module adf4158_config
  import adf4158_pkg::*;
#(
  parameter int unsigned           CLK_DIV  = 2,
  parameter int unsigned           CE_DELAY = 400,
  parameter logic [WORD_WIDTH-1:0] R7  = R7_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R6A = R6A_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R6B = R6B_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R5A = R5A_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R5B = R5B_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R4  = R4_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R3  = R3_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R2  = R2_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R1  = R1_DEFAULT,
  parameter logic [WORD_WIDTH-1:0] R0  = R0_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic muxout_i,
  output logic ce_o,
  output logic sclk_o,
  output logic data_o,
  output logic le_o,
  output logic txdata_o,
  output logic muxout_sync_o,
  output logic config_done_o
);

  localparam int unsigned CE_W = (CE_DELAY > 1) ? $clog2(CE_DELAY) : 1;
  localparam logic [CE_W-1:0]  CE_LAST  = CE_W'(CE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [CE_W-1:0]       ce_cnt_q, ce_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ce_q, ce_d;
  logic                  done_q, done_d;
  logic [1:0]            sync_q;
  logic                  start_c;
  logic                  word_done_c;
  logic [WORD_WIDTH-1:0] word_c;

  // Sequencer: state_q stays ST_SHIFT for the whole ten-word burst.
  always_comb begin
    state_d  = state_q;
    ce_cnt_d = ce_cnt_q;
    idx_d    = idx_q;
    ce_d     = ce_q;
    done_d   = done_q;
    start_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d  = ST_CE_WAIT;
          ce_d     = 1'b1;
          ce_cnt_d = '0;
          idx_d    = '0;
        end
      end
      ST_CE_WAIT: begin
        ce_cnt_d = ce_cnt_q + CE_W'(1);
        if (ce_cnt_q == CE_LAST) begin
          start_c = 1'b1;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (word_done_c) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            start_c = 1'b1;
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word mux keyed on the index the word engine is about to load.
  always_comb begin
    case (idx_d)
      4'd0:    word_c = R7;
      4'd1:    word_c = R6A;
      4'd2:    word_c = R6B;
      4'd3:    word_c = R5A;
      4'd4:    word_c = R5B;
      4'd5:    word_c = R4;
      4'd6:    word_c = R3;
      4'd7:    word_c = R2;
      4'd8:    word_c = R1;
      default: word_c = R0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ce_cnt_q <= '0;
      idx_q    <= '0;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      ce_cnt_q <= ce_cnt_d;
      idx_q    <= idx_d;
      ce_q     <= ce_d;
      done_q   <= done_d;
      sync_q   <= {sync_q[0], muxout_i};
    end
  end

  adf4158_spi_word #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_word (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_c),
    .word_i   (word_c),
    .sclk_o   (sclk_o),
    .data_o   (data_o),
    .le_o     (le_o),
    .done_c_o (word_done_c)
  );

  assign ce_o          = ce_q;
  assign config_done_o = done_q;
  assign muxout_sync_o = sync_q[1];
  assign txdata_o      = 1'b0;

endmodule

// File: tb/tb_adf4158_config.sv
// Bench for adf4158_config: two instances (default timing and CLK_DIV=1/CE_DELAY=1)
// with a serial decoder feeding a scoreboard of expected register words.
module tb_adf4158_config;

  localparam int CD0 = 2;
  localparam int CE0 = 400;
  localparam int CD1 = 1;
  localparam int CE1 = 1;

  localparam logic [31:0] WORDS [10] = '{
    32'h0000_0007, 32'h0000_0006, 32'h0080_0006, 32'h0000_0005, 32'h0080_0005,
    32'h0018_0104, 32'h0000_0043, 32'h0040_800A, 32'h0000_0001, 32'h803C_0000
  };

  logic       clk;
  logic       rst;
  logic       muxout;
  logic [1:0] en, ce, sclk, data, le, txd, msync, done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int c0     = 0;

  logic [31:0] exp_q [2][$];
  logic [31:0] sh [2];
  int nbits [2], le_cnt [2], le_w [2], rises [2];
  int first_rise [2], last_rise [2], ce_at [2], done_at [2];
  logic sclk_p [2], le_p [2], done_p [2];
  logic mux_prev, mux_chk, txd_seen;

  adf4158_config #(.CLK_DIV(CD0), .CE_DELAY(CE0)) dut0 (
    .clk(clk), .rst(rst), .enable_i(en[0]), .muxout_i(muxout),
    .ce_o(ce[0]), .sclk_o(sclk[0]), .data_o(data[0]), .le_o(le[0]),
    .txdata_o(txd[0]), .muxout_sync_o(msync[0]), .config_done_o(done[0])
  );

  adf4158_config #(.CLK_DIV(CD1), .CE_DELAY(CE1)) dut1 (
    .clk(clk), .rst(rst), .enable_i(en[1]), .muxout_i(muxout),
    .ce_o(ce[1]), .sclk_o(sclk[1]), .data_o(data[1]), .le_o(le[1]),
    .txdata_o(txd[1]), .muxout_sync_o(msync[1]), .config_done_o(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cd(int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  function automatic int ced(int i);
    return (i == 0) ? CE0 : CE1;
  endfunction

  function automatic logic [6:0] outs(int i);
    return {ce[i], sclk[i], data[i], le[i], txd[i], msync[i], done[i]};
  endfunction

  task automatic chk(int i, string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed=0x%0h expected=0x%0h", tag, i, obs, exp);
    end
  endtask

  task automatic arm(int i);
    sh[i] = '0; nbits[i] = 0; le_cnt[i] = 0; le_w[i] = 0; rises[i] = 0;
    first_rise[i] = -1; last_rise[i] = -1; ce_at[i] = -1; done_at[i] = -1;
  endtask

  task automatic push_words(int i);
    for (int k = 0; k < 10; k++) exp_q[i].push_back(WORDS[k]);
  endtask

  // Serial decoder: shift data on sclk rise, pop and compare on le rise.
  task automatic mon(int i);
    logic [31:0] exp_w;
    logic        pending;
    if (ce[i] && ce_at[i] < 0) ce_at[i] = cyc - c0;
    if (sclk[i] && !sclk_p[i]) begin
      if (first_rise[i] < 0) first_rise[i] = cyc - c0;
      if (nbits[i] > 0) chk(i, "sclk_period", cyc - last_rise[i], 2 * cd(i));
      last_rise[i] = cyc;
      sh[i] = {sh[i][30:0], data[i]};
      nbits[i]++;
      rises[i]++;
    end
    if (le[i] && !le_p[i]) begin
      chk(i, "bits_per_word", nbits[i], 32);
      chk(i, "data_in_latch", 32'(data[i]), 0);
      pending = (exp_q[i].size() != 0);
      chk(i, "word_expected", 32'(pending), 1);
      if (pending) begin
        exp_w = exp_q[i].pop_front();
        chk(i, "word", sh[i], exp_w);
      end
      le_cnt[i]++;
      nbits[i] = 0;
    end
    if (!le[i] && le_p[i]) begin
      chk(i, "le_width", le_w[i], cd(i));
      le_w[i] = 0;
    end
    if (le[i]) le_w[i]++;
    if (done[i] && !done_p[i]) done_at[i] = cyc - c0;
    sclk_p[i] = sclk[i];
    le_p[i]   = le[i];
    done_p[i] = done[i];
  endtask

  task automatic tick();
    logic m_entry;
    m_entry = muxout;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) mon(i);
    if (mux_chk)
      for (int i = 0; i < 2; i++) chk(i, "muxout_sync", 32'(msync[i]), 32'(mux_prev));
    mux_prev = m_entry;
    txd_seen = txd_seen | (|txd);
  endtask

  task automatic run_checks(int i);
    chk(i, "ce_rise", ce_at[i], 1);
    chk(i, "first_sclk_rise", first_rise[i], 1 + ced(i) + cd(i));
    chk(i, "config_done_rise", done_at[i], 1 + ced(i) + 660 * cd(i));
    chk(i, "le_pulses", le_cnt[i], 10);
    chk(i, "scoreboard_left", exp_q[i].size(), 0);
    chk(i, "sclk_rises", rises[i], 320);
    chk(i, "done_bus_idle", 32'({sclk[i], data[i], le[i]}), 0);
    chk(i, "done_ce", 32'(ce[i]), 1);
  endtask

  initial begin
    rst = 1'b1; en = 2'b00; muxout = 1'b0;
    mux_prev = 1'b0; mux_chk = 1'b0; txd_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sclk_p[i] = 1'b0; le_p[i] = 1'b0; done_p[i] = 1'b0;
      arm(i);
    end

    // Reset, then stay idle with enable low.
    repeat (5) tick();
    for (int i = 0; i < 2; i++) chk(i, "reset_outputs", 32'(outs(i)), 0);
    rst = 1'b0;
    c0 = cyc;
    repeat (100) tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "idle_outputs", 32'(outs(i)), 0);
      chk(i, "idle_sclk_rises", rises[i], 0);
    end

    // Nominal sequence on both instances.
    for (int i = 0; i < 2; i++) push_words(i);
    en = 2'b11;
    c0 = cyc;
    for (int k = 0; k < 3000 && done !== 2'b11; k++) tick();
    chk(0, "done_timeout", 32'(done), 32'b11);
    for (int i = 0; i < 2; i++) run_checks(i);

    // DONE ignores enable in either level.
    en = 2'b00;
    repeat (20) tick();
    en = 2'b11;
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      chk(i, "done_sticky", 32'(done[i]), 1);
      chk(i, "done_no_extra_le", le_cnt[i], 10);
      chk(i, "done_no_extra_sclk", rises[i], 320);
    end

    // Reset mid-word, 17 bits into R4.
    en = 2'b00;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) arm(i);
    push_words(0);
    en = 2'b01;
    c0 = cyc;
    for (int k = 0; k < 2000 && !(le_cnt[0] == 5 && nbits[0] == 17); k++) tick();
    chk(0, "reach_r4_bit17", 32'({le_cnt[0][3:0], nbits[0][5:0]}), 32'({4'd5, 6'd17}));
    rst = 1'b1;
    tick();
    chk(0, "midword_reset_outputs", 32'(outs(0)), 0);
    exp_q[0].delete();
    rst = 1'b0;
    en = 2'b00;
    repeat (3) tick();

    // Restart; drop enable during CE_WAIT and wiggle muxout throughout.
    arm(0);
    push_words(0);
    en = 2'b01;
    c0 = cyc;
    tick();
    en = 2'b00;
    mux_chk = 1'b1;
    for (int k = 0; k < 3000 && done[0] !== 1'b1; k++) begin
      muxout = 1'($urandom_range(0, 1));
      tick();
    end
    mux_chk = 1'b0;
    chk(0, "restart_done_timeout", 32'(done[0]), 1);
    run_checks(0);
    chk(1, "idle_inst_untouched", 32'({ce[1], done[1]}), 0);
    chk(0, "txdata_never_high", 32'(txd_seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adf4158_config.md
Name: adf4158_config

Overview:
- Power-up configuration sequencer for the ADF4158 FMCW frequency synthesizer.
- After reset, once `enable` is high, it asserts the chip enable and waits a settling delay.
- It then shifts ten 32-bit register words, MSB first, over the synthesizer's 3-wire serial bus (`sclk`/`data`/`le`), then raises `config_done`.
- `config_done` gates the downstream receive chain (FIR, FFT) in the top level.

Parameters:
- CLK_DIV, 2: half-period of `sclk` in `clk` cycles (40 MHz clk gives 10 MHz sclk); legal range ≥1.
- CE_DELAY, 400: `clk` cycles between `ce` rising and the first serial bit (10 µs at 40 MHz); legal range ≥1.
- R7, 32'h0000_0007: register 7 word.
- R6A, 32'h0000_0006: register 6, step select 0.
- R6B, 32'h0080_0006: register 6, step select 1.
- R5A, 32'h0000_0005: register 5, deviation select 0.
- R5B, 32'h0080_0005: register 5, deviation select 1.
- R4, 32'h0018_0104: register 4.
- R3, 32'h0000_0043: register 3.
- R2, 32'h0040_800A: register 2.
- R1, 32'h0000_0001: register 1.
- R0, 32'h803C_0000: register 0.

Ports:
- clk, in, 1: single system clock (40 MHz).
- rst, in, 1: synchronous reset, active-high.
- enable, in, 1: start request; sampled only in IDLE.
- muxout, in, 1: synthesizer MUXOUT (lock detect), asynchronous.
- ce, out, 1: synthesizer chip enable.
- sclk, out, 1: serial clock; idles low.
- data, out, 1: serial data.
- le, out, 1: load-enable pulse that latches a word.
- txdata, out, 1: TXDATA ramp control; tied 0.
- muxout_sync, out, 1: `muxout` after a 2-flop synchronizer.
- config_done, out, 1: high once all ten words are written; sticky until `rst`.

Behaviour:
- Reset: on any `clk` edge with `rst`=1, all outputs go to 0, the synchronizer flops clear and the FSM enters IDLE. Reset mid-sequence aborts the transfer immediately.
- States: IDLE → CE_WAIT → SHIFT → LATCH → GAP → (SHIFT of next word | DONE).
- IDLE: if `enable`=1 at edge T0, then `ce`=1 from T0+1 onward.
- CE_WAIT: lasts exactly CE_DELAY cycles.
- SHIFT: 32 bits per word, MSB (bit 31) first. Each bit lasts 2·CLK_DIV cycles:
  - `data` changes at the start of the bit with `sclk`=0 for CLK_DIV cycles;
  - then `sclk`=1 for CLK_DIV cycles;
  - `data` is stable across the whole bit, so the device samples on the `sclk` rising edge.
- LATCH: `sclk`=0, `le`=1 for CLK_DIV cycles.
- GAP: `le`=0, `sclk`=0 for CLK_DIV cycles.
- Word order (word index 0–9): R7, R6A, R6B, R5A, R5B, R4, R3, R2, R1, R0.
- Word time is 66·CLK_DIV cycles.
- DONE: `config_done`=1 from cycle T0+1+CE_DELAY+660·CLK_DIV. `ce` stays 1; `sclk`, `le` and `data` stay 0.
- `enable` falling after T0 is ignored; the sequence always completes. In DONE, `enable` has no effect; re-programming requires `rst`.
- `data`=0 whenever not in SHIFT.
- `txdata`=0 always.
- `muxout_sync` lags `muxout` by 2 cycles.
- Exactly 32 rising `sclk` edges between consecutive `le` pulses, and exactly 10 `le` pulses per sequence.

Decomposition:
- Package adf4158_pkg holds:
  - default register constants;
  - NUM_WORDS=10;
  - WORD_WIDTH=32;
  - the FSM state enum.
- One sub-module, adf4158_spi_word: loads a 32-bit word on start, produces `sclk`/`data`/`le` timing, and pulses done after GAP.
- The top sequencer holds the word-index counter, word mux, CE delay counter and synchronizer.

Test Plan:
- Reset then idle: `rst`=1 for 5 cycles, `enable`=0 for 100 cycles → all outputs 0 and no `sclk` edges.
- Nominal sequence with defaults, `enable`=1 at T0:
  - `ce`=1 at T0+1;
  - first `sclk` rise at T0+1+400+2;
  - `config_done` rises at T0+1721.
- Serial decode: a bench monitor shifts `data` on `sclk` rises and captures on `le` → words 0x00000007, 0x00000006, 0x00800006, 0x00000005, 0x00800005, 0x00180104, 0x00000043, 0x0040800A, 0x00000001, 0x803C0000, in order; 10 `le` pulses each 2 cycles wide.
- CLK_DIV=1, CE_DELAY=1 → `sclk` period 2 cycles and `config_done` at T0+662; decoded words unchanged.
- Reset mid-word (after 17 bits of R4): `rst`=1 → next cycle all outputs 0; re-enable → full sequence restarts from R7.
- `enable` dropped during CE_WAIT; `muxout` toggled → sequence still completes; `muxout_sync` follows with 2-cycle lag; `txdata` stays 0.
